// File: rtl/pipe_stall_ctrl.sv
// Pipeline enable/flush sequencer: resolves load-use hazards, taken-branch flushes
// and multi-cycle data-memory waits, and tracks stall statistics.
module pipe_stall_ctrl #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 31,
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             memwb_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_timeout
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [REG_W-1:0]  ZERO_IDX = REG_W'(ZERO_REG);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t            state, state_next;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic              timeout_set;
  logic              load_use;
  logic              mem_stall;

  assign load_use = ex_mem_read && (ex_rd != ZERO_IDX) &&
                    ((id_use_rn && (ex_rd == id_rn)) || (id_use_rm && (ex_rd == id_rm)));

  // A dropped mem_req while waiting counts as completion, so one term covers both states.
  assign mem_stall = mem_req && !mem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      wait_cnt     <= '0;
      stall_cycles <= '0;
      mem_timeout  <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
      if (timeout_set)
        mem_timeout <= 1'b1;
      if (!pc_en && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

  always_comb begin
    state_next   = state;
    wait_next    = wait_cnt;
    timeout_set  = 1'b0;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    memwb_bubble = 1'b0;

    if (mem_stall) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_en     = 1'b0;
      memwb_bubble = 1'b1;
      state_next   = MEM_WAIT;
      if (state == RUN)
        wait_next = WAIT_W'(1);
      else if (wait_cnt != WAIT_MAX)
        wait_next = wait_cnt + 1'b1;
      if (wait_next == WAIT_MAX)
        timeout_set = 1'b1;
    end else begin
      state_next = RUN;
      wait_next  = '0;
      if (load_use) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end else if (br_taken) begin
        ifid_flush = 1'b1;
      end
    end

    // Hold every bank and inject NOPs for as long as reset is asserted.
    if (!reset) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_en     = 1'b0;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b1;
      memwb_bubble = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl (MAX_WAIT = 4, CNT_W = 4).
module tb_pipe_stall_ctrl;

  localparam int REG_W    = 5;
  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             ex_mem_read;
  logic [REG_W-1:0] ex_rd, id_rn, id_rm;
  logic             id_use_rn, id_use_rm;
  logic             br_taken, mem_req, mem_ready;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_bubble, memwb_bubble;
  logic [CNT_W-1:0] stall_cycles;
  logic             mem_timeout;

  int assertCount = 0;
  int failCount   = 0;
  int expStall    = 0;

  pipe_stall_ctrl #(
    .REG_W(REG_W), .ZERO_REG(31), .CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .id_rn(id_rn), .id_rm(id_rm),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .br_taken(br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .memwb_bubble(memwb_bubble), .stall_cycles(stall_cycles), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkEnables(input string tag, input logic [4:0] en);
    checkOutput({tag, ".en"}, 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'(en));
  endtask

  task automatic applyStimulus(input logic lmr, input logic [4:0] rd, input logic [4:0] rn,
                               input logic urn, input logic br, input logic req, input logic rdy);
    ex_mem_read = lmr;
    ex_rd       = rd;
    id_rn       = rn;
    id_use_rn   = urn;
    id_rm       = 5'd0;
    id_use_rm   = 1'b0;
    br_taken    = br;
    mem_req     = req;
    mem_ready   = rdy;
    #1;
  endtask

  // Advance one clock and account for a stall edge if pc_en was low before it.
  task automatic tick();
    if (!pc_en && expStall < 15) expStall++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkEnables("reset", 5'b00000);
    checkOutput("reset.flush", 32'(ifid_flush), 32'd0);
    checkOutput("reset.idexb", 32'(idex_bubble), 32'd1);
    checkOutput("reset.memwbb", 32'(memwb_bubble), 32'd1);
    checkOutput("reset.stall", 32'(stall_cycles), 32'd0);
    checkOutput("reset.timeout", 32'(mem_timeout), 32'd0);

    reset = 1'b1;
    #1;
    checkEnables("release", 5'b11111);
    checkOutput("release.idexb", 32'(idex_bubble), 32'd0);
    tick();
    checkOutput("release.stall", 32'(stall_cycles), 32'd0);

    applyStimulus(1, 5'd3, 5'd3, 1, 0, 0, 0);
    checkEnables("loaduse", 5'b00111);
    checkOutput("loaduse.idexb", 32'(idex_bubble), 32'd1);
    checkOutput("loaduse.flush", 32'(ifid_flush), 32'd0);
    tick();
    checkOutput("loaduse.stall", 32'(stall_cycles), 32'd1);

    applyStimulus(1, 5'd31, 5'd31, 1, 0, 0, 0);
    checkEnables("zeroreg", 5'b11111);
    checkOutput("zeroreg.idexb", 32'(idex_bubble), 32'd0);
    applyStimulus(1, 5'd3, 5'd3, 0, 0, 0, 0);
    checkEnables("nouse", 5'b11111);
    ex_mem_read = 1'b1; ex_rd = 5'd7; id_rm = 5'd7; id_use_rm = 1'b1; #1;
    checkEnables("rm_hazard", 5'b00111);
    tick();
    checkOutput("rm_hazard.stall", 32'(stall_cycles), 32'd2);

    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkEnables("branch", 5'b11111);
    checkOutput("branch.flush", 32'(ifid_flush), 32'd1);
    tick();

    applyStimulus(1, 5'd4, 5'd4, 1, 1, 0, 0);
    checkEnables("br_lu", 5'b00111);
    checkOutput("br_lu.flush", 32'(ifid_flush), 32'd0);
    tick();
    applyStimulus(0, 5'd4, 5'd4, 1, 1, 0, 0);
    checkEnables("br_replay", 5'b11111);
    checkOutput("br_replay.flush", 32'(ifid_flush), 32'd1);
    tick();
    checkOutput("br_replay.stall", 32'(stall_cycles), 32'd3);

    // Three waiting cycles then release: no timeout yet.
    applyStimulus(1, 5'd2, 5'd2, 1, 0, 1, 0);
    checkEnables("memwait1", 5'b00000);
    checkOutput("memwait1.memwbb", 32'(memwb_bubble), 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    checkEnables("memwait2", 5'b00000);
    checkOutput("memwait2.flush", 32'(ifid_flush), 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    checkEnables("memwait3", 5'b00000);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 1, 1);
    checkEnables("memrel", 5'b11111);
    checkOutput("memrel.flush", 32'(ifid_flush), 32'd1);
    checkOutput("memrel.memwbb", 32'(memwb_bubble), 32'd0);
    tick();
    checkOutput("memrel.stall", 32'(stall_cycles), 32'd6);
    checkOutput("memrel.timeout", 32'(mem_timeout), 32'd0);

    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkEnables("cancel", 5'b11111);
    tick();
    checkOutput("cancel.stall", 32'(stall_cycles), 32'd7);
    checkOutput("cancel.timeout", 32'(mem_timeout), 32'd0);

    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 6; i++) begin
      checkEnables($sformatf("timeout%0d", i), 5'b00000);
      tick();
      checkOutput($sformatf("timeout%0d.flag", i), 32'(mem_timeout), (i >= MAX_WAIT) ? 32'd1 : 32'd0);
    end
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    checkEnables("timeout_rel", 5'b11111);
    tick();
    checkOutput("timeout_rel.flag", 32'(mem_timeout), 32'd1);
    checkOutput("timeout_rel.stall", 32'(stall_cycles), 32'(expStall));

    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkEnables("midreset", 5'b00000);
    checkOutput("midreset.idexb", 32'(idex_bubble), 32'd1);
    checkOutput("midreset.timeout", 32'(mem_timeout), 32'd0);
    checkOutput("midreset.stall", 32'(stall_cycles), 32'd0);
    expStall = 0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkEnables("postreset", 5'b11111);
    tick();
    checkOutput("postreset.stall", 32'(stall_cycles), 32'd0);

    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14 || i == 15 || i == 20)
        checkOutput($sformatf("sat%0d", i), 32'(stall_cycles), (i < 15) ? 32'(i) : 32'd15);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("sat_hold", 32'(stall_cycles), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
